// File: rtl/turn_pkg.sv
// Shared types and constants for the player-turn sequencer.
//   turn_state_t : sequencer states (idle, waiting for a move, commit, timeout, done)
//   player_t     : P1 = 0, P2 = 1
//   SECS_W       : width of the seconds-left countdown
package turn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCommit,
    StTimeout,
    StDone
  } turn_state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  localparam int unsigned SECS_W = 4;

endpackage

// File: rtl/key_debounce.sv
// Confirm-key conditioning: 2-FF synchronizer, stability counter and press-edge detector.
// The debounced level only changes once the synchronized key has disagreed with it for
// DEBOUNCE_CYCLES consecutive samples; press is a registered one-cycle pulse on each
// debounced 1->0 transition.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (chain resets to the released level, 1)
//   key_n : raw active-low pushbutton, asynchronous to clk
//   press : one-cycle pulse per debounced press
module key_debounce
  import turn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample that agrees with the debounced level restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/turn_controller.sv
// Player-turn sequencer: commits one move per debounced confirm press for the active
// player, alternates turns and optionally enforces a per-turn countdown.
// Build option: define TURN_TIMEOUT_EN to include the one-second prescaler, the
// seconds countdown and the timeout state; otherwise secs_left and timeout_pulse are 0
// and a turn waits indefinitely for a press or game_over.
//   clk, rst_n      : clock, asynchronous active-low reset
//   key_confirm_n   : raw active-low confirm pushbutton
//   game_start      : one-cycle pulse, starts or restarts a match
//   game_over       : level from the winner/draw checker
//   game_active     : match in progress
//   current_player  : 0 = P1, 1 = P2
//   move_commit     : one-cycle pulse accepting the move at the cursor
//   move_player     : owner of move_commit (0 when no commit)
//   timeout_pulse   : one-cycle pulse when a turn expires
//   secs_left       : seconds remaining in the current turn
module turn_controller
  import turn_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TURN_TIME_S     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_confirm_n,
  input  logic              game_start,
  input  logic              game_over,
  output logic              game_active,
  output logic              current_player,
  output logic              move_commit,
  output logic              move_player,
  output logic              timeout_pulse,
  output logic [SECS_W-1:0] secs_left
);

  if (CLK_HZ == 0 || TURN_TIME_S < 1 || TURN_TIME_S > 15) begin : g_bad_cfg
    $error("turn_controller: CLK_HZ must be nonzero and TURN_TIME_S within 1..15");
  end

  logic press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_confirm_n),
    .press(press)
  );

  turn_state_t state_q, state_d;
  player_t     player_q, player_d;
  player_t     move_player_q, move_player_d;
  logic        active_q, active_d;
  logic        commit_q, commit_d;
  logic        timeout_q, timeout_d;
  logic        expire;

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SECS_W-1:0] TurnSecs = SECS_W'(TURN_TIME_S);

  logic [PreW-1:0]   presc_q, presc_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic              tick;

  assign tick   = (presc_q == PreW'(CLK_HZ - 1));
  assign expire = tick && (secs_q == SECS_W'(1));

  // The timer only advances on WAIT cycles that do not leave WAIT for another reason,
  // so secs_left stays frozen through COMMIT and DONE.
  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (game_start || state_q == StCommit || state_q == StTimeout) begin
      presc_d = '0;
      secs_d  = TurnSecs;
    end else if (state_q == StWait && !game_over && !press) begin
      if (tick) begin
        presc_d = '0;
        secs_d  = secs_q - 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      secs_q  <= '0;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  assign secs_left = secs_q;
`else
  assign expire    = 1'b0;
  assign secs_left = '0;
`endif

  always_comb begin
    state_d       = state_q;
    player_d      = player_q;
    commit_d      = 1'b0;
    move_player_d = P1;
    timeout_d     = 1'b0;
    if (game_start) begin
      state_d  = StWait;
      player_d = P1;
    end else begin
      unique case (state_q)
        StWait: begin
          if (game_over) begin
            state_d = StDone;
          end else if (press) begin
            state_d       = StCommit;
            commit_d      = 1'b1;
            move_player_d = player_q;
          end else if (expire) begin
            state_d   = StTimeout;
            timeout_d = 1'b1;
          end
        end
        StCommit, StTimeout: begin
          state_d  = StWait;
          player_d = player_t'(~player_q);
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
    active_d = (state_d == StWait) || (state_d == StCommit) || (state_d == StTimeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      player_q      <= P1;
      move_player_q <= P1;
      active_q      <= 1'b0;
      commit_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      player_q      <= player_d;
      move_player_q <= move_player_d;
      active_q      <= active_d;
      commit_q      <= commit_d;
      timeout_q     <= timeout_d;
    end
  end

  assign game_active    = active_q;
  assign current_player = player_q;
  assign move_commit    = commit_q;
  assign move_player    = move_player_q;
  assign timeout_pulse  = timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed scenarios plus randomized key,
// game_start and game_over traffic, compared every cycle against a behavioural model
// (sliding-window debounce, elapsed-cycle turn timer).
module tb_turn_controller;

  localparam int unsigned ClkHz     = 10;
  localparam int unsigned DebCycles = 4;
  localparam int unsigned TurnS     = 3;
`ifdef TURN_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam int PhIdle = 0, PhWait = 1, PhCommit = 2, PhTimeout = 3, PhDone = 4;

  logic       clk = 1'b0;
  logic       rst_n, key_confirm_n, game_start, game_over;
  logic       game_active, current_player, move_commit, move_player, timeout_pulse;
  logic [3:0] secs_left;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_phase, m_player, m_wait_n, m_commit_player, m_stable;
  bit m_press_pending;
  int m_khist[$];

  int dut_commits, dut_timeouts;
  int commit_at, tout_at, go_left, run_left;
  bit rnd_key;

  turn_controller #(
    .CLK_HZ         (ClkHz),
    .DEBOUNCE_CYCLES(DebCycles),
    .TURN_TIME_S    (TurnS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_confirm_n (key_confirm_n),
    .game_start    (game_start),
    .game_over     (game_over),
    .game_active   (game_active),
    .current_player(current_player),
    .move_commit   (move_commit),
    .move_player   (move_player),
    .timeout_pulse (timeout_pulse),
    .secs_left     (secs_left)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase         = PhIdle;
    m_player        = 0;
    m_wait_n        = 0;
    m_commit_player = 0;
    m_stable        = 1;
    m_press_pending = 1'b0;
    m_khist.delete();
    for (int i = 0; i < DebCycles + 2; i++) m_khist.push_back(1);
  endfunction

  // One clock edge of the reference behaviour, given the inputs sampled at that edge.
  function automatic void model_edge(input bit gs, input bit go, input bit k);
    bit pr;
    bit all_diff;
    pr = m_press_pending;
    if (gs) begin
      m_phase  = PhWait;
      m_player = 0;
      m_wait_n = 0;
    end else begin
      case (m_phase)
        PhWait: begin
          if (go) m_phase = PhDone;
          else if (pr) begin
            m_phase         = PhCommit;
            m_commit_player = m_player;
          end else if (TimeoutEn && (m_wait_n + 1 == TurnS * ClkHz)) m_phase = PhTimeout;
          else m_wait_n++;
        end
        PhCommit, PhTimeout: begin
          m_phase  = PhWait;
          m_player = 1 - m_player;
          m_wait_n = 0;
        end
        default: ;
      endcase
    end
    // Debounced level flips once the key, two samples late, has differed for
    // DebCycles consecutive samples.
    m_khist.push_front(int'(k));
    void'(m_khist.pop_back());
    all_diff = 1'b1;
    for (int i = 2; i < DebCycles + 2; i++) if (m_khist[i] == m_stable) all_diff = 1'b0;
    m_press_pending = 1'b0;
    if (all_diff) begin
      m_stable        = 1 - m_stable;
      m_press_pending = (m_stable == 0);
    end
  endfunction

  function automatic int exp_secs();
    if (!TimeoutEn || m_phase == PhIdle || m_phase == PhTimeout) return 0;
    return TurnS - m_wait_n / ClkHz;
  endfunction

  task automatic step(input bit gs, input bit go, input bit k);
    game_start    = gs;
    game_over     = go;
    key_confirm_n = k;
    @(posedge clk);
    model_edge(gs, go, k);
    #1;
    check_eq("game_active", game_active,
             m_phase == PhWait || m_phase == PhCommit || m_phase == PhTimeout);
    check_eq("current_player", current_player, m_player);
    check_eq("move_commit", move_commit, m_phase == PhCommit);
    check_eq("move_player", move_player, (m_phase == PhCommit) ? m_commit_player : 0);
    check_eq("timeout_pulse", timeout_pulse, m_phase == PhTimeout);
    check_eq("secs_left", secs_left, exp_secs());
    if (move_commit === 1'b1) dut_commits++;
    if (timeout_pulse === 1'b1) dut_timeouts++;
  endtask

  initial begin
    rst_n         = 1'b0;
    key_confirm_n = 1'b0;
    game_start    = 1'b0;
    game_over     = 1'b0;
    dut_commits   = 0;
    dut_timeouts  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_game_active", game_active, 0);
    check_eq("rst_current_player", current_player, 0);
    check_eq("rst_move_commit", move_commit, 0);
    check_eq("rst_move_player", move_player, 0);
    check_eq("rst_timeout_pulse", timeout_pulse, 0);
    check_eq("rst_secs_left", secs_left, 0);

    // Key held low through reset release, still idle
    rst_n = 1'b1;
    model_reset();
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check_eq("held_through_reset_commits", dut_commits, 0);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // First move: key low 10 cycles
    step(1'b1, 1'b0, 1'b1);
    dut_commits = 0;
    commit_at   = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (commit_at != 0 && i == commit_at + 1) begin
        check_eq("player_after_commit", current_player, 1);
        check_eq("secs_after_commit", secs_left, TimeoutEn ? TurnS : 0);
      end
      if (move_commit === 1'b1 && commit_at == 0) begin
        commit_at = i;
        check_eq("commit_move_player", move_player, 0);
      end
    end
    check_eq("commit_latency", commit_at, 7);
    check_eq("commit_count_hold10", dut_commits, 1);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // Short glitches never commit; a long hold commits once
    step(1'b1, 1'b0, 1'b1);
    dut_commits = 0;
    repeat (5) begin
      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1);
    end
    check_eq("glitch_commits", dut_commits, 0);
    step(1'b1, 1'b0, 1'b1);
    dut_commits = 0;
    repeat (50) step(1'b0, 1'b0, 1'b0);
    check_eq("hold50_commits", dut_commits, 1);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // Turn expiry
    step(1'b1, 1'b0, 1'b1);
    dut_timeouts = 0;
    tout_at      = 0;
`ifdef TURN_TIMEOUT_EN
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (timeout_pulse === 1'b1 && tout_at == 0) tout_at = i + 1;
      if (i == 9) check_eq("secs_3", secs_left, 3);
      if (i == 10) check_eq("secs_2", secs_left, 2);
      if (i == 20) check_eq("secs_1", secs_left, 1);
      if (i == 30) check_eq("secs_0", secs_left, 0);
      if (i == 31) begin
        check_eq("player_after_timeout", current_player, 1);
        check_eq("secs_after_timeout", secs_left, 3);
      end
    end
    check_eq("timeout_cycle", tout_at, 31);
    check_eq("timeout_count", dut_timeouts, 1);
`else
    repeat (200) step(1'b0, 1'b0, 1'b1);
    check_eq("no_timeout_count", dut_timeouts, 0);
    check_eq("no_timeout_secs", secs_left, 0);
    check_eq("no_timeout_player", current_player, 0);
    check_eq("no_timeout_active", game_active, 1);
`endif

    // game_over in the same cycle the press reaches the sequencer
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    check_eq("player_before_over", current_player, 1);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    dut_commits = 0;
    step(1'b0, 1'b1, 1'b0);
    check_eq("over_press_commit", move_commit, 0);
    check_eq("over_active", game_active, 0);
    check_eq("over_player_held", current_player, 1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    check_eq("done_commits", dut_commits, 0);
    check_eq("done_active", game_active, 0);
    check_eq("done_player_held", current_player, 1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("restart_active", game_active, 1);
    check_eq("restart_player", current_player, 0);

    // Randomized traffic
    run_left = 0;
    go_left  = 0;
    rnd_key  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      bit gs;
      if (run_left == 0) begin
        rnd_key  = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      if (go_left == 0 && $urandom_range(0, 99) == 0) go_left = $urandom_range(1, 5);
      gs = ($urandom_range(0, 119) == 0);
      step(gs, go_left != 0, rnd_key);
      if (go_left != 0) go_left--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
